// File: rtl/ppi_bus_master.sv
// Host-side bus initiator that sequences 8255 PPI CPU-bus cycles (CS_, A, RD_, WR_, PORTD_IO).
// Optional bit-set/reset request port is enabled by defining PPI_MASTER_BSR_EN.
module ppi_bus_master #(
    parameter int SETUP_CYC  = 1,
    parameter int STROBE_CYC = 2,
    parameter int HOLD_CYC   = 1
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_write,
    input  logic [1:0] req_addr,
    input  logic [7:0] req_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    inout  wire  [7:0] PORTD_IO,
    output logic [1:0] A,
    output logic       RD_,
    output logic       WR_,
    output logic       CS_
`ifdef PPI_MASTER_BSR_EN
    ,
    input  logic       bsr_valid,
    input  logic [2:0] bsr_bit,
    input  logic       bsr_val,
    output logic       bsr_ready
`endif
);

    // Counter reload values; a zero-length phase still lasts one cycle.
    localparam logic [3:0] SETUP_LD  = (SETUP_CYC  <= 1) ? 4'd0 : 4'(SETUP_CYC  - 1);
    localparam logic [3:0] STROBE_LD = (STROBE_CYC <= 1) ? 4'd0 : 4'(STROBE_CYC - 1);
    localparam logic [3:0] HOLD_LD   = (HOLD_CYC   <= 1) ? 4'd0 : 4'(HOLD_CYC   - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        STROBE = 2'd2,
        HOLD   = 2'd3
    } state_t;

    state_t      state_q;
    logic [3:0]  cnt_q;
    logic        ready_q;
    logic        rsp_valid_q;
    logic [7:0]  rdata_q;
    logic [1:0]  addr_q;
    logic        cs_n_q;
    logic        rd_n_q;
    logic        wr_n_q;
    logic        oe_q;
    logic        write_q;
    logic [7:0]  wdata_q;

    logic        accept_d;
    logic        acc_write_d;
    logic [1:0]  acc_addr_d;
    logic [7:0]  acc_wdata_d;

    // Request selection; the generic request always wins over a BSR request.
    always_comb begin
        accept_d    = ready_q & req_valid;
        acc_write_d = req_write;
        acc_addr_d  = req_addr;
        acc_wdata_d = req_wdata;
`ifdef PPI_MASTER_BSR_EN
        if (!req_valid) begin
            accept_d    = ready_q & bsr_valid;
            acc_write_d = 1'b1;
            acc_addr_d  = 2'd3;
            acc_wdata_d = {4'b0000, bsr_bit, bsr_val};
        end
`endif
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            ready_q     <= 1'b1;
            rsp_valid_q <= 1'b0;
            rdata_q     <= 8'h00;
            addr_q      <= 2'b00;
            cs_n_q      <= 1'b1;
            rd_n_q      <= 1'b1;
            wr_n_q      <= 1'b1;
            oe_q        <= 1'b0;
            write_q     <= 1'b0;
            wdata_q     <= 8'h00;
        end else begin
            rsp_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept_d) begin
                        write_q <= acc_write_d;
                        addr_q  <= acc_addr_d;
                        wdata_q <= acc_wdata_d;
                        oe_q    <= acc_write_d;
                        cs_n_q  <= 1'b0;
                        ready_q <= 1'b0;
                        cnt_q   <= SETUP_LD;
                        state_q <= SETUP;
                    end
                end
                SETUP: begin
                    if (cnt_q == 4'd0) begin
                        rd_n_q  <= write_q;
                        wr_n_q  <= ~write_q;
                        cnt_q   <= STROBE_LD;
                        state_q <= STROBE;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                STROBE: begin
                    if (cnt_q == 4'd0) begin
                        // Read data is sampled on the edge that raises RD_.
                        if (!write_q) begin
                            rdata_q <= PORTD_IO;
                        end
                        rd_n_q  <= 1'b1;
                        wr_n_q  <= 1'b1;
                        cnt_q   <= HOLD_LD;
                        state_q <= HOLD;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                HOLD: begin
                    if (cnt_q == 4'd0) begin
                        cs_n_q      <= 1'b1;
                        oe_q        <= 1'b0;
                        ready_q     <= 1'b1;
                        rsp_valid_q <= 1'b1;
                        state_q     <= IDLE;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign req_ready = ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rdata_q;
    assign A         = addr_q;
    assign CS_       = cs_n_q;
    assign RD_       = rd_n_q;
    assign WR_       = wr_n_q;
    assign PORTD_IO  = oe_q ? wdata_q : 8'hzz;

`ifdef PPI_MASTER_BSR_EN
    assign bsr_ready = ready_q & ~req_valid;
`endif

endmodule

// File: tb/tb_ppi_bus_master.sv
// Self-checking bench for ppi_bus_master: directed bus-cycle traces plus randomized transactions
// compared cycle by cycle against a phase-timing model of the PPI bus protocol.
module tb_ppi_bus_master;

    localparam int S_N = 1;
    localparam int T_N = 2;
    localparam int H_N = 1;
    localparam int TOT = S_N + T_N + H_N + 1;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic       req_write = 1'b0;
    logic [1:0] req_addr = 2'd0;
    logic [7:0] req_wdata = 8'h00;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    tri1  [7:0] portd_bus;
    logic [1:0] A;
    logic       RD_;
    logic       WR_;
    logic       CS_;
`ifdef PPI_MASTER_BSR_EN
    logic       bsr_valid = 1'b0;
    logic [2:0] bsr_bit = 3'd0;
    logic       bsr_val = 1'b0;
    logic       bsr_ready;
`endif

    logic [7:0] tb_rd_data = 8'h00;
    logic [7:0] last_rd = 8'h00;
    int         n_tests = 0;
    int         n_fail = 0;

    // Responder side of the bus: the PPI drives data only while RD_ is low.
    assign portd_bus = (RD_ === 1'b0) ? tb_rd_data : 8'hzz;

    ppi_bus_master dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .PORTD_IO  (portd_bus),
        .A         (A),
        .RD_       (RD_),
        .WR_       (WR_),
        .CS_       (CS_)
`ifdef PPI_MASTER_BSR_EN
        ,
        .bsr_valid (bsr_valid),
        .bsr_bit   (bsr_bit),
        .bsr_val   (bsr_val),
        .bsr_ready (bsr_ready)
`endif
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Issues one transaction (entered at a negedge) and checks every cycle from accept
    // through the rsp_valid cycle. Optionally raises the next request while busy.
    task automatic txn(input bit w, input logic [1:0] ad, input logic [7:0] wd,
                       input logic [7:0] rdat, input bit use_bsr,
                       input bit chain, input bit nw, input logic [1:0] nad,
                       input logic [7:0] nwd, output int waits);
        bit strobe;
        logic [7:0] exp_bus;
        logic [7:0] exp_rd;
        tb_rd_data = rdat;
`ifdef PPI_MASTER_BSR_EN
        if (use_bsr) bsr_valid = 1'b1;
`endif
        if (!use_bsr) begin
            req_valid = 1'b1;
            req_write = w;
            req_addr  = ad;
            req_wdata = wd;
        end
        waits = 0;
        while (req_ready !== 1'b1 && waits < 64) begin
            @(negedge CLK);
            waits++;
        end
        if (req_ready !== 1'b1) begin
            check("accept_timeout", 32'd0, 32'd1);
            req_valid = 1'b0;
            return;
        end
        @(posedge CLK);
        #1;
        req_valid = 1'b0;
`ifdef PPI_MASTER_BSR_EN
        bsr_valid = 1'b0;
`endif
        for (int k = 1; k <= TOT; k++) begin
            @(negedge CLK);
            strobe  = (k > S_N) && (k <= S_N + T_N);
            exp_bus = (w && k < TOT) ? wd : ((strobe && !w) ? rdat : 8'hFF);
            exp_rd  = (!w && k > S_N + T_N) ? rdat : last_rd;
            check("cs_n",      {31'd0, CS_},       {31'd0, k == TOT});
            check("rd_n",      {31'd0, RD_},       {31'd0, !(strobe && !w)});
            check("wr_n",      {31'd0, WR_},       {31'd0, !(strobe && w)});
            check("addr",      {30'd0, A},         {30'd0, ad});
            check("bus",       {24'd0, portd_bus}, {24'd0, exp_bus});
            check("rsp_valid", {31'd0, rsp_valid}, {31'd0, k == TOT});
            check("req_ready", {31'd0, req_ready}, {31'd0, k == TOT});
            check("rsp_rdata", {24'd0, rsp_rdata}, {24'd0, exp_rd});
            if (chain && k == 2) begin
                req_valid = 1'b1;
                req_write = nw;
                req_addr  = nad;
                req_wdata = nwd;
            end
        end
        if (!w) last_rd = rdat;
    endtask

    initial begin
        int waits;
        bit pend, cw, nw, chain;
        logic [1:0] ca, na;
        logic [7:0] cd, nd, crd;

        // Reset held for two cycles.
        repeat (2) @(negedge CLK);
        check("rst_cs_n",  {31'd0, CS_},       32'd1);
        check("rst_rd_n",  {31'd0, RD_},       32'd1);
        check("rst_wr_n",  {31'd0, WR_},       32'd1);
        check("rst_bus",   {24'd0, portd_bus}, 32'hFF);
        check("rst_ready", {31'd0, req_ready}, 32'd1);
        check("rst_rdata", {24'd0, rsp_rdata}, 32'h00);
        check("rst_rsp",   {31'd0, rsp_valid}, 32'd0);
        check("rst_addr",  {30'd0, A},         32'd0);
        RESET = 1'b0;
        @(negedge CLK);

        // Control word write, then a read of port A.
        txn(1'b1, 2'd3, 8'b1001_1011, 8'h00, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00, waits);
        txn(1'b0, 2'd0, 8'h00, 8'hE7, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00, waits);
        check("read_e7", {24'd0, rsp_rdata}, 32'hE7);

        // Back-to-back: write B=3C with read C raised while the write is busy.
        txn(1'b1, 2'd1, 8'h3C, 8'h00, 1'b0, 1'b1, 1'b0, 2'd2, 8'h00, waits);
        txn(1'b0, 2'd2, 8'h00, 8'h5A, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00, waits);
        check("b2b_wait", waits, 32'd0);

        // Asynchronous reset in the middle of a write strobe.
        req_valid = 1'b1; req_write = 1'b1; req_addr = 2'd2; req_wdata = 8'hA5;
        @(posedge CLK); #1; req_valid = 1'b0;
        @(posedge CLK); #2;
        check("pre_rst_wr_n", {31'd0, WR_}, 32'd0);
        RESET = 1'b1;
        #1;
        check("async_wr_n",  {31'd0, WR_},       32'd1);
        check("async_cs_n",  {31'd0, CS_},       32'd1);
        check("async_bus",   {24'd0, portd_bus}, 32'hFF);
        check("async_rsp",   {31'd0, rsp_valid}, 32'd0);
        check("async_rdata", {24'd0, rsp_rdata}, 32'h00);
        last_rd = 8'h00;
        repeat (2) @(negedge CLK);
        RESET = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            check("post_rst_rsp",  {31'd0, rsp_valid}, 32'd0);
            check("post_rst_cs_n", {31'd0, CS_},       32'd1);
        end
        txn(1'b0, 2'd1, 8'h00, 8'h81, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00, waits);

`ifdef PPI_MASTER_BSR_EN
        bsr_bit = 3'd5; bsr_val = 1'b1; bsr_valid = 1'b1;
        check("bsr_ready_idle", {31'd0, bsr_ready}, 32'd1);
        txn(1'b1, 2'd0, 8'h77, 8'h00, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00, waits);
        txn(1'b1, 2'd3, 8'b0000_1011, 8'h00, 1'b1, 1'b0, 1'b0, 2'd0, 8'h00, waits);
`endif

        // Randomized transactions, some chained back-to-back.
        pend = 1'b0; nw = 1'b0; na = 2'd0; nd = 8'h00;
        for (int i = 0; i < 20; i++) begin
            if (pend) begin
                cw = nw; ca = na; cd = nd;
            end else begin
                cw = 1'($urandom_range(0, 1));
                ca = 2'($urandom_range(0, 3));
                cd = 8'($urandom_range(0, 255));
            end
            crd   = 8'($urandom_range(0, 255));
            nw    = 1'($urandom_range(0, 1));
            na    = 2'($urandom_range(0, 3));
            nd    = 8'($urandom_range(0, 255));
            chain = (i < 19) && ($urandom_range(0, 2) == 0);
            txn(cw, ca, cd, crd, 1'b0, chain, nw, na, nd, waits);
            if (pend) check("rand_b2b_wait", waits, 32'd0);
            pend = chain;
            if (!chain) repeat ($urandom_range(0, 2)) @(negedge CLK);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
